// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - two-source interrupt controller: sync, edge detect, pend, mask, dispatch
// Timer is source 1 (bit 0, highest priority); external async line is source 2 (bit 1).
module irq_controller #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_timer,
  input  logic       irq_ext,
  input  logic       reti,
  input  logic       mask_we,
  input  logic [1:0] mask_in,
  output logic       s_intr1,
  output logic       s_intr2,
  output logic       busy,
  output logic [1:0] pending,
  output logic [1:0] mask,
  output logic       reti_err
);

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ext_hist_q, ext_hist_d;
  logic                   tmr_hist_q, tmr_hist_d;
  logic [1:0]             pending_q, pending_d;
  logic [1:0]             mask_q, mask_d;
  logic                   s_intr1_q, s_intr1_d;
  logic                   s_intr2_q, s_intr2_d;
  logic                   busy_q, busy_d;
  logic                   reti_err_q, reti_err_d;

  logic       ext_edge;
  logic       tmr_edge;
  logic [1:0] eligible;
  logic [1:0] served;
  logic       dispatch;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], irq_ext};
    ext_hist_d = sync_q[SYNC_STAGES-1];
    tmr_hist_d = irq_timer;
    ext_edge   = sync_q[SYNC_STAGES-1] & ~ext_hist_q;
    tmr_edge   = irq_timer & ~tmr_hist_q;

    eligible = pending_q & mask_q;
    dispatch = (state_q == IDLE) && (eligible != 2'b00) && !reti;
    served   = 2'b00;
    if (dispatch) begin
      served = eligible[0] ? 2'b01 : 2'b10;
    end

    // A fresh edge on the edge that services the same source is kept pending.
    pending_d = (pending_q & ~served) | {ext_edge, tmr_edge};
    mask_d    = mask_we ? mask_in : mask_q;
    s_intr1_d = served[0];
    s_intr2_d = served[1];

    state_d    = state_q;
    busy_d     = busy_q;
    reti_err_d = reti_err_q;
    case (state_q)
      IDLE: begin
        if (reti) begin
          reti_err_d = 1'b1;
        end else if (dispatch) begin
          state_d = SERVICE;
          busy_d  = 1'b1;
        end
      end
      SERVICE: begin
        if (reti) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      ext_hist_q <= 1'b0;
      tmr_hist_q <= 1'b0;
      pending_q  <= 2'b00;
      mask_q     <= 2'b00;
      s_intr1_q  <= 1'b0;
      s_intr2_q  <= 1'b0;
      busy_q     <= 1'b0;
      reti_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      ext_hist_q <= ext_hist_d;
      tmr_hist_q <= tmr_hist_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      s_intr1_q  <= s_intr1_d;
      s_intr2_q  <= s_intr2_d;
      busy_q     <= busy_d;
      reti_err_q <= reti_err_d;
    end
  end

  assign s_intr1  = s_intr1_q;
  assign s_intr2  = s_intr2_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign mask     = mask_q;
  assign reti_err = reti_err_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - randomized and directed bench for irq_controller against a behavioural model
module tb_irq_controller;

  localparam int NS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       irq_timer = 1'b0;
  logic       irq_ext = 1'b0;
  logic       reti = 1'b0;
  logic       mask_we = 1'b0;
  logic [1:0] mask_in = 2'b00;
  logic       s_intr1;
  logic       s_intr2;
  logic       busy;
  logic [1:0] pending;
  logic [1:0] mask;
  logic       reti_err;

  irq_controller #(.SYNC_STAGES(NS)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_timer (irq_timer),
    .irq_ext   (irq_ext),
    .reti      (reti),
    .mask_we   (mask_we),
    .mask_in   (mask_in),
    .s_intr1   (s_intr1),
    .s_intr2   (s_intr2),
    .busy      (busy),
    .pending   (pending),
    .mask      (mask),
    .reti_err  (reti_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: sample history of irq_ext plus the architectural state.
  bit       m_s1, m_s2, m_busy, m_err, prev_tmr;
  bit [1:0] m_pend, m_mask;
  bit       ext_log[$];

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_busy = 0; m_err = 0; prev_tmr = 0;
    m_pend = 2'b00; m_mask = 2'b00;
    ext_log.delete();
    for (int i = 0; i < NS + 2; i++) ext_log.push_back(1'b0);
  endfunction

  function automatic void model_edge();
    bit       t_rise, e_rise, go;
    bit [1:0] elig, served;
    ext_log.push_front(irq_ext);
    e_rise = ext_log[NS] & ~ext_log[NS+1];
    void'(ext_log.pop_back());
    t_rise   = irq_timer & ~prev_tmr;
    prev_tmr = irq_timer;
    elig   = m_pend & m_mask;
    go     = !m_busy && (elig != 2'b00) && !reti;
    served = 2'b00;
    if (go) served = elig[0] ? 2'b01 : 2'b10;
    m_s1 = served[0];
    m_s2 = served[1];
    if (!m_busy && reti) m_err = 1;
    if (m_busy && reti) m_busy = 0;
    else if (go) m_busy = 1;
    m_pend = (m_pend & ~served) | {e_rise, t_rise};
    if (mask_we) m_mask = mask_in;
  endfunction

  function automatic logic [7:0] obs();
    return {s_intr1, s_intr2, busy, pending, mask, reti_err};
  endfunction

  function automatic logic [7:0] expv();
    return {m_s1, m_s2, m_busy, m_pend, m_mask, m_err};
  endfunction

  task automatic step(input logic t, input logic e, input logic r, input logic we, input logic [1:0] mi);
    @(negedge clk);
    irq_timer = t; irq_ext = e; reti = r; mask_we = we; mask_in = mi;
    model_edge();
    @(posedge clk);
    #1;
    check_eq("cycle", obs(), expv());
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    irq_timer = 0; irq_ext = 0; reti = 0; mask_we = 0; mask_in = 2'b00;
    #1;
    check_eq("async_reset", obs(), 8'h00);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic       rt, re, rr, rw;
  logic [1:0] rm;

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 check_eq("reset_state", obs(), 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // timer dispatch
    step(0, 0, 0, 1, 2'b01);
    step(1, 0, 0, 0, 2'b00);
    check_eq("tmr_pend", {6'b0, pending}, 8'h01);
    step(0, 0, 0, 0, 2'b00);
    check_eq("tmr_pulse", {5'b0, s_intr1, s_intr2, busy}, 8'h05);
    step(0, 0, 0, 0, 2'b00);
    check_eq("tmr_one_cycle", {6'b0, s_intr1, busy}, 8'h01);
    step(0, 0, 1, 0, 2'b00);
    check_eq("tmr_ret", {7'b0, busy}, 8'h00);

    // priority with coincident edges
    step(0, 0, 0, 1, 2'b11);
    for (int i = 0; i < NS; i++) step(0, 1, 0, 0, 2'b00);
    step(1, 1, 0, 0, 2'b00);
    check_eq("prio_pend", {4'b0, s_intr1, s_intr2, pending}, 8'h03);
    step(1, 1, 0, 0, 2'b00);
    check_eq("prio_first", {4'b0, s_intr1, s_intr2, pending}, 8'h0a);
    step(1, 1, 1, 0, 2'b00);
    step(1, 1, 0, 0, 2'b00);
    check_eq("prio_second", {4'b0, s_intr1, s_intr2, pending}, 8'h04);
    step(0, 0, 1, 0, 2'b00);

    // masking
    step(0, 0, 0, 1, 2'b00);
    for (int i = 0; i < NS + 2; i++) step(0, 0, 0, 0, 2'b00);
    for (int i = 0; i < NS + 21; i++) begin
      step(0, 1, 0, 0, 2'b00);
      check_eq("mask_nopulse", {6'b0, s_intr1, s_intr2}, 8'h00);
    end
    check_eq("mask_pend", {6'b0, pending}, 8'h02);
    step(0, 1, 0, 1, 2'b10);
    check_eq("mask_write_edge", {6'b0, s_intr1, s_intr2}, 8'h00);
    step(0, 1, 0, 0, 2'b00);
    check_eq("mask_pulse", {6'b0, s_intr1, s_intr2}, 8'h01);
    step(0, 0, 1, 0, 2'b00);

    // coincident set/clear and no nesting
    step(0, 0, 0, 1, 2'b00);
    step(1, 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);
    step(0, 0, 0, 1, 2'b01);
    step(1, 0, 0, 0, 2'b00);
    check_eq("coin", {4'b0, s_intr1, busy, pending}, 8'h0d);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 2'b00);
      check_eq("no_nest", {7'b0, s_intr1}, 8'h00);
    end
    step(0, 0, 1, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);
    check_eq("coin_second", {7'b0, s_intr1}, 8'h01);
    step(0, 0, 1, 0, 2'b00);

    // spurious return
    step(1, 0, 0, 0, 2'b00);
    step(1, 0, 1, 0, 2'b00);
    check_eq("spur", {6'b0, s_intr1, reti_err}, 8'h01);
    step(0, 0, 0, 0, 2'b00);
    check_eq("spur_next", {5'b0, s_intr1, busy, reti_err}, 8'h07);
    step(0, 0, 1, 0, 2'b00);
    step(0, 0, 0, 0, 2'b00);
    check_eq("err_sticky", {7'b0, reti_err}, 8'h01);
    do_reset();

    // randomized traffic
    rt = 0; re = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        rt = 0; re = 0;
      end
      if ($urandom_range(0, 3) == 0) rt = ~rt;
      if ($urandom_range(0, 4) == 0) re = ~re;
      rr = ($urandom_range(0, 7) == 0);
      rw = ($urandom_range(0, 9) == 0);
      rm = 2'($urandom);
      step(rt, re, rr, rw, rm);
      check_eq("exclusive", {7'b0, s_intr1 & s_intr2}, 8'h00);
    end

    // reset mid-service with both requests pending
    do_reset();
    step(0, 0, 0, 1, 2'b11);
    step(1, 0, 0, 0, 2'b00);
    step(1, 0, 0, 0, 2'b00);
    step(0, 1, 0, 0, 2'b00);
    for (int i = 0; i < NS; i++) step(1, 1, 0, 0, 2'b00);
    check_eq("svc_pend", {5'b0, busy, pending}, 8'h07);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
